bmp_header_writer: RTL and testbench
====================================

Name: bmp_header_writer

Overview:
- Parametrised BMP (BITMAPINFOHEADER) header generator for the cropping path.
- Takes the crop box on start and computes row padding, image size and file size.
- Streams the 54-byte header into frame memory as 1- or 2-byte words through a wren/addr/wrdata port, with a wait_req stall.
- Runs before the pixel writer, which fills from byte offset 54.

Parameters:
- WORD_BYTES, 2, bytes per memory write (1 or 2). Bytes are little-endian within a word.
- ADDR_W, 24, memory address width.
- BASE_ADDR, 0, word address of header byte 0.
- COORD_W, 11, crop coordinate width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request pulse or level; sampled in IDLE and DONE
- xMin, xMax, yMin, yMax  in  COORD_W each  inclusive crop box
- bpp_sel  in  1  0 = 24 bpp, 1 = 32 bpp; sampled with start
- wait_req  in  1  memory stall; current write is held while high
- addr  out  ADDR_W  word address
- wren  out  1  write enable
- wrdata  out  8*WORD_BYTES  write data
- busy  out  1  high in CALC and WRITE
- done  out  1  level, high in DONE
- err  out  1  high in DONE if the box was invalid

Behaviour:
- Reset: state IDLE; addr, wren, wrdata, busy, done, err all 0; byte index k = 0. Reset mid-WRITE aborts immediately; no further writes.
- States: IDLE, CALC, WRITE, DONE.
- IDLE -> CALC on start: latch box and bpp_sel.
- CALC (exactly 1 cycle):
  - W = xMax-xMin+1, H = yMax-yMin+1.
  - Bpx = 3 or 4; R = W*Bpx; P = (R+3) & ~3; S = P*H; F = S+54.
  - All arithmetic 32-bit unsigned, registered.
  - If xMax<xMin or yMax<yMin: go to DONE with err=1 and no writes. Otherwise go to WRITE.
- WRITE:
  - wren=1, addr = BASE_ADDR + k/WORD_BYTES.
  - wrdata[8j+7:8j] = header byte k+j.
  - If wait_req=0 the write is accepted that cycle and k += WORD_BYTES. If wait_req=1, addr/wrdata/k are held.
  - After the write containing byte 53 is accepted: wren=0, go to DONE.
  - Write count: 27 writes (WORD_BYTES=2) or 54 (WORD_BYTES=1). Minimum latency from start to done is 1 + 1 + writes cycles.
- DONE: done=1, wren=0. start returns to CALC with err and done cleared the next cycle and the new box latched. Otherwise remain.
- start in CALC or WRITE is ignored.
- Header bytes (multi-byte fields little-endian):
  - 0..1 = 0x42, 0x4D
  - 2..5 = F
  - 6..9 = 0
  - 10..13 = 54
  - 14..17 = 40
  - 18..21 = W
  - 22..25 = H
  - 26..27 = 1
  - 28..29 = 24 or 32
  - 30..33 = 0
  - 34..37 = S
  - 38..53 = 0
- wren is never high outside WRITE.

Optional Feature:
- BMP_TOPDOWN_EN defined: bytes 22..25 = two's-complement -H (top-down row order). done additionally requires nothing new.
- Undefined: bytes 22..25 = +H (bottom-up).

Decomposition:
- Package bmp_pkg holds:
  - HDR_BYTES=54, PIX_OFFSET=54, DIB_SIZE=40, SIG_B=8'h42, SIG_M=8'h4D
  - state enum typedef
  - packed struct of computed fields {W, H, bpp, S, F}
- Sub-module bmp_hdr_byte_mux: combinational, returns header byte for index k (0..53) given the field struct. It is instantiated WORD_BYTES times, with index k+j.

Test Plan:
- Box (0,99,0,99), 24bpp, WORD_BYTES=2, wait_req=0:
  - 27 writes at addr 0..26.
  - word0=0x4D42, word1=0x7566, word2=0x0000 (F=30054).
  - word17=0x7530 (S=30000).
  - done high 29 cycles after start.
- Box W=3, H=2, 24bpp:
  - P=12, S=24, F=78.
  - Bytes 34..37 = 18 00 00 00; bytes 2..5 = 4E 00 00 00.
  - 32bpp same box: P=12, byte 28 = 0x20.
- wait_req high for 3 cycles at k=10: addr=5 and wrdata held constant, no double write. Total cycles +3.
- xMax<xMin: CALC -> DONE with err=1, zero wren cycles. Restart with a valid box: err cleared, full header written.
- rst_n low at 5th write: wren=0 next cycle, all outputs 0. Subsequent start writes the full header from addr 0.
- start held high throughout run: no restart until DONE. Then one re-run per DONE visit, with identical data.

Source files
------------

// File: rtl/bmp_pkg.sv
// Shared constants, state encoding and computed-field record for the BMP header writer.
package bmp_pkg;

    localparam int         HDR_BYTES  = 54;
    localparam int         PIX_OFFSET = 54;
    localparam int         DIB_SIZE   = 40;
    localparam logic [7:0] SIG_B      = 8'h42;
    localparam logic [7:0] SIG_M      = 8'h4D;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_WRITE,
        ST_DONE
    } bmp_state_e;

    // h holds the value as it appears in the header (negated for top-down builds)
    typedef struct packed {
        logic [31:0] w;
        logic [31:0] h;
        logic [15:0] bpp;
        logic [31:0] s;
        logic [31:0] f;
    } bmp_fields_t;

    function automatic logic [7:0] le_byte(input logic [31:0] v, input logic [1:0] n);
        return v[{n, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/bmp_header_writer_if.sv
// Frame-memory write port used by the header writer: word address, enable, data and stall.
interface bmp_header_writer_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] addr;
    logic              wren;
    logic [DATA_W-1:0] wrdata;
    logic              wait_req;

    modport master (output addr, output wren, output wrdata, input wait_req);
    modport slave  (input addr, input wren, input wrdata, output wait_req);
endinterface

// File: rtl/bmp_hdr_byte_mux.sv
// Combinational lookup of one BITMAPINFOHEADER byte (index 0..53) from the computed fields.
module bmp_hdr_byte_mux
    import bmp_pkg::*;
(
    input  logic [5:0]  i_idx,
    input  bmp_fields_t i_fields,
    output logic [7:0]  o_byte
);

    // Reserved, compression, resolution and palette fields all fall through to zero
    always_comb begin
        o_byte = 8'h00;
        if (i_idx == 6'd0)
            o_byte = SIG_B;
        else if (i_idx == 6'd1)
            o_byte = SIG_M;
        else if (i_idx <= 6'd5)
            o_byte = le_byte(i_fields.f, 2'(i_idx - 6'd2));
        else if (i_idx >= 6'd10 && i_idx <= 6'd13)
            o_byte = le_byte(32'(PIX_OFFSET), 2'(i_idx - 6'd10));
        else if (i_idx >= 6'd14 && i_idx <= 6'd17)
            o_byte = le_byte(32'(DIB_SIZE), 2'(i_idx - 6'd14));
        else if (i_idx >= 6'd18 && i_idx <= 6'd21)
            o_byte = le_byte(i_fields.w, 2'(i_idx - 6'd18));
        else if (i_idx >= 6'd22 && i_idx <= 6'd25)
            o_byte = le_byte(i_fields.h, 2'(i_idx - 6'd22));
        else if (i_idx == 6'd26)
            o_byte = 8'h01;
        else if (i_idx >= 6'd28 && i_idx <= 6'd29)
            o_byte = le_byte({16'h0000, i_fields.bpp}, 2'(i_idx - 6'd28));
        else if (i_idx >= 6'd34 && i_idx <= 6'd37)
            o_byte = le_byte(i_fields.s, 2'(i_idx - 6'd34));
    end

endmodule

// File: rtl/bmp_header_writer.sv
// BMP header generator: latches a crop box, sizes the image and streams the 54-byte header.
// Build option BMP_TOPDOWN_EN writes a negative height (top-down rows); default is bottom-up.
module bmp_header_writer
    import bmp_pkg::*;
#(
    parameter int WORD_BYTES = 2,
    parameter int ADDR_W     = 24,
    parameter int BASE_ADDR  = 0,
    parameter int COORD_W    = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [COORD_W-1:0] i_xMin,
    input  logic [COORD_W-1:0] i_xMax,
    input  logic [COORD_W-1:0] i_yMin,
    input  logic [COORD_W-1:0] i_yMax,
    input  logic               i_bpp_sel,
    bmp_header_writer_if.master mem,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    bmp_state_e          r_state;
    bmp_state_e          w_next_state;
    logic [5:0]          r_k;
    logic [COORD_W-1:0]  r_xMin, r_xMax, r_yMin, r_yMax;
    logic                r_bpp32;
    logic                r_err;
    bmp_fields_t         r_fields;
    bmp_fields_t         w_calc;
    logic [31:0]         w_width, w_height, w_row, w_pad_row;
    logic                w_box_bad;
    logic                w_accept;
    logic                w_last;
    logic                w_take_start;
    logic [8*WORD_BYTES-1:0] w_bytes;

    assign w_box_bad    = (r_xMax < r_xMin) || (r_yMax < r_yMin);
    assign w_last       = (int'(r_k) + WORD_BYTES) >= HDR_BYTES;
    assign w_take_start = i_start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign o_err        = r_err;

    // Rows are padded up to a 4-byte multiple; all sizes wrap at 32 bits
    always_comb begin
        w_width     = 32'(r_xMax) - 32'(r_xMin) + 32'd1;
        w_height    = 32'(r_yMax) - 32'(r_yMin) + 32'd1;
        w_row       = w_width * (r_bpp32 ? 32'd4 : 32'd3);
        w_pad_row   = (w_row + 32'd3) & ~32'd3;
        w_calc.w    = w_width;
`ifdef BMP_TOPDOWN_EN
        w_calc.h    = 32'd0 - w_height;
`else
        w_calc.h    = w_height;
`endif
        w_calc.bpp  = r_bpp32 ? 16'd32 : 16'd24;
        w_calc.s    = w_pad_row * w_height;
        w_calc.f    = w_calc.s + 32'(PIX_OFFSET);
    end

    for (genvar j = 0; j < WORD_BYTES; j++) begin : g_byte
        bmp_hdr_byte_mux u_mux (
            .i_idx    (r_k + 6'(j)),
            .i_fields (r_fields),
            .o_byte   (w_bytes[8*j +: 8])
        );
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        mem.wren     = 1'b0;
        mem.addr     = '0;
        mem.wrdata   = '0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start)
                    w_next_state = ST_CALC;
            end
            ST_CALC: begin
                o_busy       = 1'b1;
                w_next_state = w_box_bad ? ST_DONE : ST_WRITE;
            end
            ST_WRITE: begin
                o_busy     = 1'b1;
                mem.wren   = 1'b1;
                mem.addr   = ADDR_W'(BASE_ADDR) + ADDR_W'(int'(r_k) / WORD_BYTES);
                mem.wrdata = w_bytes;
                w_accept   = !mem.wait_req;
                if (w_accept && w_last)
                    w_next_state = ST_DONE;
            end
            ST_DONE: begin
                o_done = 1'b1;
                if (i_start)
                    w_next_state = ST_CALC;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_k      <= '0;
            r_xMin   <= '0;
            r_xMax   <= '0;
            r_yMin   <= '0;
            r_yMax   <= '0;
            r_bpp32  <= 1'b0;
            r_err    <= 1'b0;
            r_fields <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_take_start) begin
                r_xMin  <= i_xMin;
                r_xMax  <= i_xMax;
                r_yMin  <= i_yMin;
                r_yMax  <= i_yMax;
                r_bpp32 <= i_bpp_sel;
                r_err   <= 1'b0;
                r_k     <= '0;
            end
            if (r_state == ST_CALC) begin
                r_fields <= w_calc;
                r_err    <= w_box_bad;
            end
            if (w_accept)
                r_k <= w_last ? 6'd0 : r_k + 6'(WORD_BYTES);
        end
    end

endmodule

// File: tb/tb_bmp_header_writer.sv
// Self-checking bench for bmp_header_writer: vector table, hand-built corner sequences, random boxes.
module tb_bmp_header_writer;

    localparam int WB     = 2;
    localparam int AW     = 24;
    localparam int NWORDS = 54 / WB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iStart;
    logic [10:0] iXMin, iXMax, iYMin, iYMax;
    logic        iBppSel;
    logic        oBusy, oDone, oErr;

    int checkCount = 0;
    int passCount  = 0;
    int wrenCount  = 0;
    logic [AW+8*WB-1:0] capQ[$];
    logic [7:0] expHdr [54];
    bit   randStall  = 1'b0;
    bit   forceStall = 1'b0;
    logic calcErr, calcBusy;

    typedef struct {
        int          xmin, xmax, ymin, ymax;
        bit          b32;
        logic [31:0] expS, expF;
        bit          expErr;
        int          expCyc;
    } vec_t;

    vec_t tbl [7];

    bmp_header_writer_if #(.ADDR_W(AW), .DATA_W(8*WB)) memIf ();

    bmp_header_writer #(
        .WORD_BYTES (WB),
        .ADDR_W     (AW),
        .BASE_ADDR  (0),
        .COORD_W    (11)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (iStart),
        .i_xMin    (iXMin),
        .i_xMax    (iXMax),
        .i_yMin    (iYMin),
        .i_yMax    (iYMax),
        .i_bpp_sel (iBppSel),
        .mem       (memIf),
        .o_busy    (oBusy),
        .o_done    (oDone),
        .o_err     (oErr)
    );

    always #5 clk = ~clk;

    // Stall is applied just after each rising edge so it is stable over the whole cycle
    always @(posedge clk) begin
        #1;
        memIf.wait_req = randStall ? ($urandom_range(0, 3) == 0) : forceStall;
    end

    always @(negedge clk) begin
        if (memIf.wren === 1'b1) begin
            wrenCount++;
            if (memIf.wait_req === 1'b0)
                capQ.push_back({memIf.addr, memIf.wrdata});
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    function automatic void putLe(input int off, input longint v);
        for (int b = 0; b < 4; b++)
            expHdr[off + b] = 8'(v >> (8 * b));
    endfunction

    // Reference header built straight from the BMP field definitions
    function automatic bit buildModel(input int xmin, input int xmax, input int ymin, input int ymax, input bit b32);
        longint w, h, row, padded, s, f;
        w      = xmax - xmin + 1;
        h      = ymax - ymin + 1;
        row    = w * (b32 ? 4 : 3);
        padded = ((row + 3) / 4) * 4;
        s      = padded * h;
        f      = s + 54;
        for (int i = 0; i < 54; i++)
            expHdr[i] = 8'h00;
        expHdr[0] = 8'h42;
        expHdr[1] = 8'h4D;
        putLe(2, f);
        putLe(10, 54);
        putLe(14, 40);
        putLe(18, w);
`ifdef BMP_TOPDOWN_EN
        putLe(22, -h);
`else
        putLe(22, h);
`endif
        putLe(26, 1 + ((b32 ? 32 : 24) << 16));
        putLe(34, s);
        return (xmax < xmin) || (ymax < ymin);
    endfunction

    function automatic logic [AW+8*WB-1:0] expWord(input int i);
        logic [8*WB-1:0] d;
        for (int b = 0; b < WB; b++)
            d[8*b +: 8] = expHdr[i*WB + b];
        return {AW'(i), d};
    endfunction

    function automatic logic [8*WB-1:0] capData(input int i);
        if (i < capQ.size())
            return capQ[i][8*WB-1:0];
        return '0;
    endfunction

    task automatic applyStimulus(input int xmin, input int xmax, input int ymin, input int ymax, input bit b32);
        iXMin   = 11'(xmin);
        iXMax   = 11'(xmax);
        iYMin   = 11'(ymin);
        iYMax   = 11'(ymax);
        iBppSel = b32;
    endtask

    task automatic waitDone(input bit hold, output int cyc);
        cyc = 0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            cyc++;
            #1;
            if (!hold)
                iStart = 1'b0;
            if (cyc == 1) begin
                calcErr  = oErr;
                calcBusy = oBusy;
            end
            if (oDone)
                break;
        end
        checkOutput("done reached", oDone, 1);
    endtask

    task automatic runFrame(input bit hold, output int cyc);
        capQ.delete();
        wrenCount = 0;
        @(posedge clk);
        #1;
        iStart = 1'b1;
        waitDone(hold, cyc);
    endtask

    task automatic checkFrame(input string name, input bit bad);
        if (bad) begin
            checkOutput({name, " wren cycles"}, wrenCount, 0);
            checkOutput({name, " err"}, oErr, 1);
        end else begin
            checkOutput({name, " write count"}, capQ.size(), NWORDS);
            checkOutput({name, " err"}, oErr, 0);
            for (int i = 0; i < capQ.size() && i < NWORDS; i++)
                checkOutput($sformatf("%s word%0d", name, i), capQ[i], expWord(i));
        end
    endtask

    initial begin
        int  cyc;
        bit  bad, found;
        int  xmin, xmax, ymin, ymax;
        bit  b32;

        tbl[0] = '{0, 99, 0, 99, 1'b0, 32'd30000, 32'd30054, 1'b0, 29};
        tbl[1] = '{0, 2, 0, 1, 1'b0, 32'd24, 32'd78, 1'b0, 29};
        tbl[2] = '{0, 2, 0, 1, 1'b1, 32'd24, 32'd78, 1'b0, 29};
        tbl[3] = '{5, 4, 0, 0, 1'b0, 32'd0, 32'd0, 1'b1, 2};
        tbl[4] = '{10, 10, 3, 3, 1'b1, 32'd4, 32'd58, 1'b0, 29};
        tbl[5] = '{0, 2047, 0, 0, 1'b0, 32'd6144, 32'd6198, 1'b0, 29};
        tbl[6] = '{1, 1, 0, 4, 1'b0, 32'd20, 32'd74, 1'b0, 29};

        rst_n  = 1'b0;
        iStart = 1'b0;
        applyStimulus(0, 0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset wren", memIf.wren, 0);
        checkOutput("reset addr/data", {memIf.addr, memIf.wrdata}, 0);
        checkOutput("reset status", {oBusy, oDone, oErr}, 0);
        rst_n = 1'b1;

        $display("[TB] vector table");
        for (int t = 0; t < 7; t++) begin
            applyStimulus(tbl[t].xmin, tbl[t].xmax, tbl[t].ymin, tbl[t].ymax, tbl[t].b32);
            bad = buildModel(tbl[t].xmin, tbl[t].xmax, tbl[t].ymin, tbl[t].ymax, tbl[t].b32);
            runFrame(1'b0, cyc);
            checkOutput($sformatf("vec%0d cycles", t), cyc, tbl[t].expCyc);
            checkOutput($sformatf("vec%0d calc busy/err", t), {calcBusy, calcErr}, 2'b10);
            checkFrame($sformatf("vec%0d", t), tbl[t].expErr);
            if (!tbl[t].expErr) begin
                checkOutput($sformatf("vec%0d S", t), {capData(18), capData(17)}, tbl[t].expS);
                checkOutput($sformatf("vec%0d F", t), {capData(2), capData(1)}, tbl[t].expF);
            end
        end

        $display("[TB] stall at byte 10");
        applyStimulus(0, 99, 0, 99, 1'b0);
        bad = buildModel(0, 99, 0, 99, 1'b0);
        fork
            runFrame(1'b0, cyc);
            begin
                found = 1'b0;
                for (int n = 0; n < 100; n++) begin
                    @(negedge clk);
                    if (memIf.wren && memIf.addr == 4) begin
                        found = 1'b1;
                        break;
                    end
                end
                checkOutput("stall reached addr4", found, 1);
                forceStall = 1'b1;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    checkOutput($sformatf("stall hold %0d", s), {memIf.wren, memIf.addr, memIf.wrdata},
                                {1'b1, expWord(5)});
                end
                forceStall = 1'b0;
            end
        join
        checkOutput("stall cycles", cyc, 32);
        checkFrame("stall", 1'b0);

        $display("[TB] reset during write");
        applyStimulus(0, 99, 0, 99, 1'b0);
        @(posedge clk);
        #1;
        iStart = 1'b1;
        @(posedge clk);
        #1;
        iStart = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (memIf.wren && memIf.addr == 4) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("abort reached 5th write", found, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort wren", memIf.wren, 0);
        checkOutput("abort addr/data", {memIf.addr, memIf.wrdata}, 0);
        checkOutput("abort status", {oBusy, oDone, oErr}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wrenCount = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("abort no writes", wrenCount, 0);
        bad = buildModel(0, 99, 0, 99, 1'b0);
        runFrame(1'b0, cyc);
        checkFrame("after abort", 1'b0);

        $display("[TB] start held high");
        applyStimulus(3, 9, 2, 6, 1'b1);
        bad = buildModel(3, 9, 2, 6, 1'b1);
        runFrame(1'b1, cyc);
        checkOutput("held first cycles", cyc, 29);
        checkFrame("held first", 1'b0);
        capQ.delete();
        waitDone(1'b1, cyc);
        iStart = 1'b0;
        checkOutput("held rerun leaves done", {calcBusy, calcErr}, 2'b10);
        checkOutput("held rerun cycles", cyc, 29);
        checkFrame("held rerun", 1'b0);
        wrenCount = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("held release stays done", {oDone, oBusy}, 2'b10);
        checkOutput("held release no writes", wrenCount, 0);

        $display("[TB] random boxes with random stalls");
        randStall = 1'b1;
        for (int r = 0; r < 12; r++) begin
            xmin = $urandom_range(0, 30);
            xmax = xmin + $urandom_range(0, 20);
            ymin = $urandom_range(0, 30);
            ymax = ymin + $urandom_range(0, 10);
            b32  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0 && xmin > 0)
                xmax = xmin - 1;
            applyStimulus(xmin, xmax, ymin, ymax, b32);
            bad = buildModel(xmin, xmax, ymin, ymax, b32);
            runFrame(1'b0, cyc);
            checkFrame($sformatf("rand%0d", r), bad);
        end
        randStall = 1'b0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
